// File: rtl/pheap_root_pkg.sv
// Shared types for the pipelined max-heap: key/value, heap entry, level opcode
// and the root controller state encoding.
package pheapTypes;

   localparam int KEY_W = 8;
   localparam int VAL_W = 8;
   localparam int CAP_W = 8;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] value;
   } kv_t;

   // cap counts the free slots in the subtree rooted at this entry
   typedef struct packed {
      logic             active;
      logic [CAP_W-1:0] cap;
      kv_t              kv;
   } entry_t;

   typedef enum logic {
      LEQ = 1'b0,
      DEQ = 1'b1
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      LAUNCH = 2'd2,
      COOL   = 2'd3
   } root_state_t;

   localparam kv_t    KV_EMPTY    = '0;
   localparam entry_t ENTRY_EMPTY = '0;

   function automatic logic [CAP_W-1:0] root_cap(input int levels);
      root_cap = CAP_W'((1 << levels) - 1);
   endfunction

endpackage

// File: rtl/pheap_child_sel.sv
// Chooses which of two child entries an operation continues into: free capacity
// for an enqueue, largest active key for a dequeue.
module pheap_child_sel
   import pheapTypes::*;
(
   input  entry_t l_i,
   input  entry_t r_i,
   output logic   enq_pos_o,
   output logic   deq_pos_o,
   output logic   deq_any_o
);

   logic l_free;
   logic r_free;

   assign l_free = (l_i.cap != '0);
   assign r_free = (r_i.cap != '0);

   // Enqueue steers toward the smaller key so subtrees stay balanced in value
   assign enq_pos_o = (l_free && r_free) ? (l_i.kv.key > r_i.kv.key) :
                      (l_free ? 1'b0 : 1'b1);

   assign deq_any_o = l_i.active || r_i.active;
   assign deq_pos_o = (l_i.active && r_i.active) ? (l_i.kv.key < r_i.kv.key) :
                      (l_i.active ? 1'b0 : 1'b1);

endmodule

// File: rtl/pheap_root.sv
// Level-1 controller of the pipelined max-heap: owns the root entry and hands
// work that must continue downward to the level-2 stage with a one-cycle start.
module pheap_root
   import pheapTypes::*;
#(
   parameter int LEVELS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enq_i,
   input  logic        deq_i,
   input  kv_t         kv_i,
   output logic        ready_o,
   output kv_t         kv_o,
   output logic        kv_valid_o,
   output logic        err_o,
   output logic        empty_o,
   output logic        full_o,
   input  entry_t      rBotL,
   input  entry_t      rBotR,
   output logic        start_o,
   output logic        pos_o,
   output opcode_t     op_o,
   output kv_t         kv_down_o,
   output root_state_t state_o
);

   root_state_t      state_q;
   entry_t           root_q;
   opcode_t          req_op_q;
   kv_t              kv_in_q;
   kv_t              kv_q;
   logic             kv_valid_q;
   logic             err_q;
   logic             start_q;
   logic             pos_q;
   opcode_t          op_q;
   kv_t              kv_down_q;

   logic             enq_pos;
   logic             deq_pos;
   logic             deq_any;
   logic [CAP_W-1:0] cap_dec_d;
   logic [CAP_W-1:0] cap_inc_d;

   pheap_child_sel u_sel (
      .l_i       (rBotL),
      .r_i       (rBotR),
      .enq_pos_o (enq_pos),
      .deq_pos_o (deq_pos),
      .deq_any_o (deq_any)
   );

   assign cap_dec_d = (root_q.cap != '0) ? root_q.cap - 1'b1 : root_q.cap;
   assign cap_inc_d = root_q.cap + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         root_q     <= '{active: 1'b0, cap: root_cap(LEVELS), kv: KV_EMPTY};
         req_op_q   <= LEQ;
         kv_in_q    <= KV_EMPTY;
         kv_q       <= KV_EMPTY;
         kv_valid_q <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         pos_q      <= 1'b0;
         op_q       <= LEQ;
         kv_down_q  <= KV_EMPTY;
      end else begin
         kv_valid_q <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (enq_i && deq_i) begin
                  err_q <= 1'b1;
               end else if (enq_i || deq_i) begin
                  req_op_q <= enq_i ? LEQ : DEQ;
                  if (enq_i) kv_in_q <= kv_i;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (req_op_q == LEQ) begin
                  if (!root_q.active) begin
                     root_q  <= '{active: 1'b1, cap: cap_dec_d, kv: kv_in_q};
                     state_q <= IDLE;
                  end else if (root_q.cap != '0) begin
                     // Equal keys send the newcomer down, keeping the older entry on top
                     root_q.cap <= cap_dec_d;
                     if (kv_in_q.key > root_q.kv.key) begin
                        root_q.kv <= kv_in_q;
                        kv_down_q <= root_q.kv;
                     end else begin
                        kv_down_q <= kv_in_q;
                     end
                     pos_q   <= enq_pos;
                     op_q    <= LEQ;
                     start_q <= 1'b1;
                     state_q <= LAUNCH;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  kv_valid_q <= 1'b1;
                  if (root_q.active) begin
                     kv_q       <= root_q.kv;
                     root_q.cap <= cap_inc_d;
                     if (deq_any) begin
                        root_q.kv <= deq_pos ? rBotR.kv : rBotL.kv;
                        pos_q     <= deq_pos;
                        op_q      <= DEQ;
                        kv_down_q <= KV_EMPTY;
                        start_q   <= 1'b1;
                        state_q   <= LAUNCH;
                     end else begin
                        root_q.active <= 1'b0;
                        root_q.kv     <= KV_EMPTY;
                        state_q       <= IDLE;
                     end
                  end else begin
                     kv_q    <= KV_EMPTY;
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            // Level 2 runs SET_OUT and its memory write while we sit in COOL
            LAUNCH:  state_q <= COOL;
            COOL:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o    = (state_q == IDLE) && !rst;
   assign kv_o       = kv_q;
   assign kv_valid_o = kv_valid_q;
   assign err_o      = err_q;
   assign empty_o    = !root_q.active;
   assign full_o     = (root_q.cap == '0);
   assign start_o    = start_q;
   assign pos_o      = pos_q;
   assign op_o       = op_q;
   assign kv_down_o  = kv_down_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_pheap_root.sv
// Bench for pheap_root with LEVELS=2: the heap is modelled as a multiset of keys
// and level 2 is emulated as two leaf entries driven into rBotL/rBotR.
module tb_pheap_root;
  import pheapTypes::*;

  localparam int LV    = 2;
  localparam int SLOTS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_i;
  logic        deq_i;
  kv_t         kv_i;
  logic        ready_o;
  kv_t         kv_o;
  logic        kv_valid_o;
  logic        err_o;
  logic        empty_o;
  logic        full_o;
  entry_t      rBotL;
  entry_t      rBotR;
  logic        start_o;
  logic        pos_o;
  opcode_t     op_o;
  kv_t         kv_down_o;
  root_state_t state_o;

  pheap_root #(.LEVELS(LV)) dut (
    .clk        (clk),
    .rst        (rst),
    .enq_i      (enq_i),
    .deq_i      (deq_i),
    .kv_i       (kv_i),
    .ready_o    (ready_o),
    .kv_o       (kv_o),
    .kv_valid_o (kv_valid_o),
    .err_o      (err_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .rBotL      (rBotL),
    .rBotR      (rBotR),
    .start_o    (start_o),
    .pos_o      (pos_o),
    .op_o       (op_o),
    .kv_down_o  (kv_down_o),
    .state_o    (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // keys the whole heap must currently hold
  logic [KEY_W-1:0] exp_q[$];
  // level-2 leaf memory emulation
  entry_t leaf_q[2];
  assign rBotL = leaf_q[0];
  assign rBotR = leaf_q[1];

  // per-cycle expectations consumed by the compare process
  logic    chk_en = 1'b0;
  logic    e_ready, e_start, e_valid, e_err, e_empty, e_full;
  logic    e_kv_full, e_pos;
  kv_t     e_kv;
  opcode_t e_op;
  logic [KEY_W-1:0] e_down;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic kv_t mk(input logic [7:0] k, input logic [7:0] v);
    kv_t r;
    r.key   = k;
    r.value = v;
    return r;
  endfunction

  function automatic int max_idx();
    int m = 0;
    for (int i = 1; i < exp_q.size(); i++)
      if (exp_q[i] > exp_q[m]) m = i;
    return m;
  endfunction

  task automatic reset_leaves();
    for (int i = 0; i < 2; i++) leaf_q[i] = '{active: 1'b0, cap: 8'd1, kv: KV_EMPTY};
  endtask

  task automatic set_exp(input logic r, input logic s, input logic v, input logic er);
    e_ready = r;
    e_start = s;
    e_valid = v;
    e_err   = er;
    e_empty = (exp_q.size() == 0);
    e_full  = (exp_q.size() == SLOTS);
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 16'(ready_o), 16'(e_ready));
      check("start", 16'(start_o), 16'(e_start));
      check("kv_valid", 16'(kv_valid_o), 16'(e_valid));
      check("err", 16'(err_o), 16'(e_err));
      check("empty", 16'(empty_o), 16'(e_empty));
      check("full", 16'(full_o), 16'(e_full));
      if (e_valid) begin
        if (e_kv_full) check("kv", 16'(kv_o), 16'(e_kv));
        else           check("kv_key", 16'(kv_o.key), 16'(e_kv.key));
      end
      if (e_start) begin
        check("op", 16'(op_o), 16'(e_op));
        check("pos", 16'(pos_o), 16'(e_pos));
        if (e_op == LEQ) check("kv_down_key", 16'(kv_down_o.key), 16'(e_down));
      end
    end
  end

  // driver: one request, with expectations for every cycle up to the next accept
  task automatic issue(input logic enq, input logic deq, input kv_t kv);
    int   n;
    int   mi;
    logic launch;
    logic valid;
    logic er;
    logic [KEY_W-1:0] mx;
    n = exp_q.size();
    launch = 1'b0;
    valid  = 1'b0;
    er     = 1'b0;
    @(posedge clk); #1;
    enq_i = enq; deq_i = deq; kv_i = kv;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    enq_i = 1'b0; deq_i = 1'b0;
    if (enq && deq) begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b1);
      return;
    end
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    if (enq) begin
      if (n == SLOTS) begin
        er = 1'b1;
      end else begin
        if (n > 0) begin
          launch = 1'b1;
          mx     = exp_q[max_idx()];
          e_down = (kv.key > mx) ? mx : kv.key;
          e_op   = LEQ;
          if (leaf_q[0].cap != 0 && leaf_q[1].cap != 0)
            e_pos = (leaf_q[0].kv.key <= leaf_q[1].kv.key) ? 1'b0 : 1'b1;
          else
            e_pos = (leaf_q[0].cap != 0) ? 1'b0 : 1'b1;
        end
        exp_q.push_back(kv.key);
      end
    end else begin
      valid = 1'b1;
      if (n == 0) begin
        er = 1'b1;
        e_kv = KV_EMPTY;
        e_kv_full = 1'b1;
      end else begin
        mi = max_idx();
        e_kv = mk(exp_q[mi], 8'd0);
        e_kv_full = 1'b0;
        exp_q.delete(mi);
        if (n >= 2) begin
          launch = 1'b1;
          e_op   = DEQ;
          if (leaf_q[0].active && leaf_q[1].active)
            e_pos = (leaf_q[0].kv.key >= leaf_q[1].kv.key) ? 1'b0 : 1'b1;
          else
            e_pos = leaf_q[0].active ? 1'b0 : 1'b1;
        end
      end
    end
    set_exp(!launch, launch, valid, er);
    if (launch) begin
      @(posedge clk); #1;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      // level 2 acts on what the root handed it
      if (op_o == LEQ) leaf_q[pos_o] = '{active: 1'b1, cap: 8'd0, kv: kv_down_o};
      else             leaf_q[pos_o] = '{active: 1'b0, cap: 8'd1, kv: KV_EMPTY};
    end
  endtask

  initial begin
    rst = 1'b1; enq_i = 1'b0; deq_i = 1'b0; kv_i = KV_EMPTY;
    e_kv = KV_EMPTY; e_op = LEQ; e_pos = 1'b0; e_down = '0; e_kv_full = 1'b0;
    reset_leaves();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 16'(ready_o), 16'd0);
    check("rst_empty", 16'(empty_o), 16'd1);
    check("rst_full", 16'(full_o), 16'd0);
    check("rst_start", 16'(start_o), 16'd0);
    check("rst_valid", 16'(kv_valid_o), 16'd0);
    check("rst_err", 16'(err_o), 16'd0);
    check("rst_pos", 16'(pos_o), 16'd0);
    check("rst_op", 16'(op_o), 16'(LEQ));
    check("rst_kv", 16'(kv_o), 16'(KV_EMPTY));
    check("rst_kv_down", 16'(kv_down_o), 16'(KV_EMPTY));
    check("rst_state", 16'(state_o), 16'(IDLE));
    rst = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    issue(1'b1, 1'b0, mk(8'd5, 8'd0));
    check("pin_ready_t2", 16'(ready_o), 16'd1);
    issue(1'b1, 1'b0, mk(8'd9, 8'd0));
    check("pin_down_5", 16'(kv_down_o.key), 16'd5);
    check("pin_op_leq", 16'(op_o), 16'(LEQ));
    check("pin_pos_0", 16'(pos_o), 16'd0);
    issue(1'b1, 1'b0, mk(8'd7, 8'd0));
    check("pin_down_7", 16'(kv_down_o.key), 16'd7);
    check("pin_pos_1", 16'(pos_o), 16'd1);
    check("pin_full", 16'(full_o), 16'd1);
    issue(1'b0, 1'b1, KV_EMPTY);
    check("pin_deq_9", 16'(kv_o.key), 16'd9);
    check("pin_deq_pos", 16'(pos_o), 16'd1);
    check("pin_deq_op", 16'(op_o), 16'(DEQ));
    issue(1'b1, 1'b0, mk(8'd8, 8'd0));
    check("pin_down_7b", 16'(kv_down_o.key), 16'd7);
    issue(1'b1, 1'b0, mk(8'd1, 8'd0));
    check("pin_full_err", 16'(err_o), 16'd1);
    check("pin_full_stays", 16'(full_o), 16'd1);
    issue(1'b1, 1'b1, mk(8'd2, 8'd0));
    check("pin_both_err", 16'(err_o), 16'd1);
    check("pin_both_ready", 16'(ready_o), 16'd1);
    issue(1'b0, 1'b1, KV_EMPTY);
    check("pin_deq_8", 16'(kv_o.key), 16'd8);
    issue(1'b0, 1'b1, KV_EMPTY);
    issue(1'b0, 1'b1, KV_EMPTY);
    check("pin_deq_5", 16'(kv_o.key), 16'd5);
    issue(1'b0, 1'b1, KV_EMPTY);
    check("pin_empty_kv", 16'(kv_o), 16'(KV_EMPTY));
    check("pin_empty_err", 16'(err_o), 16'd1);
    check("pin_empty_valid", 16'(kv_valid_o), 16'd1);

    // equal keys: the newcomer travels down, the older entry leaves first
    issue(1'b1, 1'b0, mk(8'd3, 8'hA1));
    issue(1'b1, 1'b0, mk(8'd3, 8'hB2));
    check("pin_tie_down", 16'(kv_down_o), 16'h03B2);
    issue(1'b0, 1'b1, KV_EMPTY);
    check("pin_tie_first", 16'(kv_o), 16'h03A1);
    issue(1'b0, 1'b1, KV_EMPTY);
    check("pin_tie_second", 16'(kv_o), 16'h03B2);

    // reset while a launch is in flight
    issue(1'b1, 1'b0, mk(8'd4, 8'd0));
    chk_en = 1'b0;
    @(posedge clk); #1;
    enq_i = 1'b1; kv_i = mk(8'd6, 8'd0);
    @(posedge clk); #1;
    enq_i = 1'b0;
    @(posedge clk); #1;
    check("pin_launch_start", 16'(start_o), 16'd1);
    rst = 1'b1;
    #1;
    check("pin_rst_start", 16'(start_o), 16'd0);
    check("pin_rst_ready", 16'(ready_o), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    reset_leaves();
    check("pin_post_empty", 16'(empty_o), 16'd1);
    check("pin_post_full", 16'(full_o), 16'd0);
    check("pin_post_state", 16'(state_o), 16'(IDLE));
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    issue(1'b1, 1'b0, mk(8'd2, 8'd0));
    issue(1'b0, 1'b1, KV_EMPTY);
    check("pin_post_deq", 16'(kv_o.key), 16'd2);
    issue(1'b0, 1'b1, KV_EMPTY);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pheap_root.md
# pheap_root

Level-1 controller of the pipelined heap (max-heap). It holds the root entry in a register, accepts enqueue/dequeue requests from the priority-queue interface, and returns dequeued keys. When an operation must continue downward, it issues a one-cycle start, the position, the op and the key to the level-2 `leq` stage. It sits between the external `pq` interface and `leq #(LEVEL=2)`.

## Interface
- `LEVELS`, default 4: total heap levels. Root reset capacity is 2^LEVELS−1, the free slots in the whole heap.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `enq_i` in 1: enqueue request, qualified by `ready_o`.
- `deq_i` in 1: dequeue request, qualified by `ready_o`.
- `kv_i` in `kv_t`: key/value to enqueue.
- `ready_o` out 1: a request is accepted in this cycle.
- `kv_o` out `kv_t`: dequeued entry, registered.
- `kv_valid_o` out 1: one-cycle pulse, `kv_o` is valid.
- `err_o` out 1: one-cycle pulse on a rejected request.
- `empty_o` out 1: root is inactive.
- `full_o` out 1: root capacity == 0.
- `rBotL`, `rBotR` in `entry_t`: level-2 entries 0 and 1, from the level-2 memory read ports.
- `start_o` out 1: start for level 2.
- `pos_o` out 1: level-2 `startPos`.
- `op_o` out `opcode_t`: level-2 op.
- `kv_down_o` out `kv_t`: level-2 `in`.

## Operation
- States: IDLE, EXEC, LAUNCH, COOL.
- `ready_o` = (state == IDLE) && !rst.
- **IDLE**
  - Exactly one of `enq_i`/`deq_i` high: register the op (and `kv_i` for an enqueue), then go to EXEC.
  - Both high: pulse `err_o` next cycle, stay in IDLE, no state change.
- **EXEC, LEQ, root inactive**
  - Root becomes {active=1, cap−1, kv_in}.
  - Next state is IDLE; no launch.
- **EXEC, LEQ, root active, cap != 0**
  - The larger key stays in the root; the smaller key goes to `kv_down_o`. On equal keys, `kv_in` goes down.
  - cap−1.
  - `pos_o` selection:
    - Both children have capacity != 0: 0 if L.key <= R.key, else 1.
    - Only L has capacity != 0: 0.
    - Otherwise: 1.
  - Next state is LAUNCH.
- **EXEC, LEQ, cap == 0**
  - `err_o` pulse; root unchanged; next state IDLE.
- **EXEC, DEQ, root active**
  - `kv_o` ← root.kv and `kv_valid_o` pulse; cap+1.
  - Neither child active: root ← inactive, `KV_EMPTY`; next state IDLE.
  - Otherwise the larger active child is promoted into the root, and `pos_o` = its index; L wins ties. Next state is LAUNCH.
- **EXEC, DEQ, root inactive**
  - `kv_o`=`KV_EMPTY`, `kv_valid_o` and `err_o` pulse; next state IDLE.
- **LAUNCH**: `start_o`=1 for exactly this cycle; next state COOL.
- **COOL**: next state IDLE. Level 2 performs its SET_OUT and memory write here.
- `op_o`, `pos_o` and `kv_down_o` are registered at the end of EXEC. They hold constant through LAUNCH and COOL, because level 2 samples `op`/`startPos` combinationally in SET_OUT.
- Capacity arithmetic uses the `entry_t` capacity width.
  - Decrement only when cap != 0.
  - Increment cannot overflow: it happens only when the root is active, so cap < max.
- Level-2 `done` is not used; sequencing is fixed-latency.

## Timing
- Request accepted in cycle T.
- EXEC in T+1: `rBotL`/`rBotR` are sampled and the root register is updated at the end of T+1.
- `kv_o`/`kv_valid_o`/`err_o` are valid in T+2.
- With a launch:
  - `start_o` is high in T+2.
  - Level 2 writes at the end of T+3.
  - `ready_o` returns in T+4, so the next EXEC (T+5) sees the updated level-2 entries.
- Without a launch: `ready_o` returns in T+2.
- Values while `rst` is high:
  - state IDLE, `ready_o`=0.
  - root inactive with cap 2^LEVELS−1, so `empty_o`=1 and `full_o`=0.
  - `start_o`=0, `kv_valid_o`=0, `err_o`=0, `pos_o`=0.
  - `op_o`=LEQ, `kv_o`=`kv_down_o`=`KV_EMPTY`.
- Reset mid-operation aborts it immediately and drops any pending launch. Level-2 memory is reset by its own owner.

## Structure
- `pheapTypes` package:
  - `root_state_t`.
  - Function `root_cap(LEVELS)`.
  - Reuse of `kv_t`, `entry_t`, `opcode_t`, `KV_EMPTY`, `ENTRY_EMPTY`.
- Sub-module `pheap_child_sel`: combinational child-choice logic.
  - Enqueue: capacity-based choice, L if L.key <= R.key.
  - Dequeue: active-based choice, larger key, L on tie.
  - Shareable with `leq`.

## Test plan
- LEVELS=2 after reset:
  - `empty_o`=1, `full_o`=0, `ready_o`=1.
  - enq key 5: no `start_o`; root={1,cap 2,5}; ready again at T+2.
- Root=5, children empty, enq 9:
  - Root becomes 9.
  - `start_o` at T+2 with `kv_down_o`=5, `op_o`=LEQ, `pos_o`=0.
  - `ready_o` low for T+1..T+3.
- Keys 9/5/7 inserted, then deq:
  - `kv_o`=9, `kv_valid_o` at T+2.
  - Root=7, `pos_o`=1, `op_o`=DEQ.
- Full heap of 3 entries, enq 1: `err_o` pulse; `full_o` stays 1; root unchanged.
- Empty heap, deq: `kv_o`=`KV_EMPTY`, with `kv_valid_o` and `err_o` pulses.
- Other error and reset cases:
  - `enq_i` and `deq_i` both high: `err_o` pulse, no state change.
  - `rst` asserted in LAUNCH: `start_o` drops immediately; IDLE/empty after release.
